// File: rtl/rdata_packetizer_pkg.sv
// Shared types and default sizing for the read-data packetizer.
// Included by rdata_packetizer, its AXIS interface and its FIFO.
package sddt_rdata_pkg;

    localparam int DEF_DATA_WIDTH = 512;
    localparam int DEF_SLOTS      = 4;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

endpackage

// File: rtl/rdata_packetizer_if.sv
// AXI-Stream bundle produced by the packetizer.
interface rdata_packetizer_if
    import sddt_rdata_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/rdata_packetizer_fifo.sv
// Synchronous FIFO with occupancy count; a push is accepted while full
// whenever a pop happens in the same cycle.
module rdata_sync_fifo
    import sddt_rdata_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + 1,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == '0);
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
        else if (!push_ok && pop_ok) count_d = count_q - (AW+1)'(1);
    end

    // Storage is not reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/rdata_packetizer.sv
// Tracks outstanding DDR reads, tags returned beats with tlast and streams
// them out over AXIS. Define RDATA_STATS_EN to add beat/packet counters.
module rdata_packetizer
    import sddt_rdata_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SLOTS      = DEF_SLOTS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SLOTS-1:0]      rd_issue,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_data_en,
    input  logic [15:0]           max_pkt_len,
    rdata_packetizer_if.master    m_axis,
    output logic [CNT_WIDTH-1:0]  outstanding,
    output logic                  credit_ok,
    output logic                  overflow,
    output logic                  underflow
`ifdef RDATA_STATS_EN
   ,output logic [31:0]           beat_count,
    output logic [31:0]           pkt_count
`endif
);
    localparam int IW    = $clog2(SLOTS + 1);
    localparam int SUM_W = CNT_WIDTH + IW + 1;
    localparam int FAW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CRW   = (CNT_WIDTH > FAW ? CNT_WIDTH : FAW) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    pkt_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] outstanding_q, outstanding_d;
    logic [15:0]          beat_idx_q, beat_idx_d, cur_idx;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 credit_ok_q, credit_ok_d;

    logic [IW-1:0]        issue_cnt;
    logic [SUM_W-1:0]     avail, nxt;
    logic                 unf_evt, sat_evt, beat_tlast;
    logic                 fifo_full, fifo_empty, fifo_pop, drop;
    logic [FAW-1:0]       fifo_count;
    logic [DATA_WIDTH:0]  fifo_dout;
    logic [CRW-1:0]       credit_sum;

    always_comb begin
        issue_cnt = '0;
        for (int i = 0; i < SLOTS; i++) issue_cnt = issue_cnt + IW'(rd_issue[i]);
    end

    // A return with nothing in flight still counts as a beat: it closes
    // a packet of its own and the count is pinned at zero.
    always_comb begin
        avail   = SUM_W'(outstanding_q) + SUM_W'(issue_cnt);
        nxt     = avail;
        unf_evt = 1'b0;
        sat_evt = 1'b0;
        if (rd_data_en) begin
            if (avail == '0) unf_evt = 1'b1;
            else             nxt = avail - SUM_W'(1);
        end
        if (nxt > SUM_W'(CNT_MAX)) begin
            nxt     = SUM_W'(CNT_MAX);
            sat_evt = 1'b1;
        end
        outstanding_d = CNT_WIDTH'(nxt);
    end

    // Packet FSM: output logic (beat index and tlast tagging).
    always_comb begin
        cur_idx    = (state_q == IN_PKT) ? beat_idx_q : '0;
        beat_tlast = rd_data_en &&
                     ((nxt == '0) ||
                      ((max_pkt_len != '0) && ({1'b0, cur_idx} + 17'd1 == {1'b0, max_pkt_len})));
        beat_idx_d = beat_idx_q;
        if (rd_data_en) beat_idx_d = beat_tlast ? '0 : cur_idx + 16'd1;
    end

    // Packet FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_data_en && !beat_tlast) state_d = IN_PKT;
            IN_PKT:  if (rd_data_en && beat_tlast)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_axis.tvalid = !fifo_empty && !rst;
        fifo_pop      = m_axis.tvalid && m_axis.tready;
        drop          = rd_data_en && fifo_full && !fifo_pop;
        overflow_d    = overflow_q | sat_evt | drop;
        underflow_d   = underflow_q | unf_evt;
        credit_sum    = CRW'(outstanding_q) + CRW'(fifo_count);
        credit_ok_d   = (credit_sum < CRW'(FIFO_DEPTH));
    end

    rdata_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_data_en),
        .din   ({beat_tlast, rd_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Packet FSM: state register, plus the remaining status flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
            beat_idx_q    <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            credit_ok_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            beat_idx_q    <= beat_idx_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            credit_ok_q   <= credit_ok_d;
        end
    end

    assign m_axis.tdata = fifo_dout[DATA_WIDTH-1:0];
    assign m_axis.tlast = m_axis.tvalid && fifo_dout[DATA_WIDTH];
    assign m_axis.tkeep = {(DATA_WIDTH/8){m_axis.tvalid}};
    assign outstanding  = outstanding_q;
    assign credit_ok    = credit_ok_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

`ifdef RDATA_STATS_EN
    logic [31:0] beat_count_q, beat_count_d, pkt_count_q, pkt_count_d;

    always_comb begin
        beat_count_d = beat_count_q + 32'(fifo_pop);
        pkt_count_d  = pkt_count_q + 32'(fifo_pop && m_axis.tlast);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_q <= '0;
            pkt_count_q  <= '0;
        end else begin
            beat_count_q <= beat_count_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign beat_count = beat_count_q;
    assign pkt_count  = pkt_count_q;
`endif
endmodule

// File: doc/rdata_packetizer.md
RDATA_PACKETIZER -- requirements
Module: rdata_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, read-data beat width in bits.
REQ-002 SHALL have parameter SLOTS, default 4, read-issue slots per clock (one per DDR4 command slot).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two, beats of internal buffering.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, outstanding-read counter width.
REQ-005 SHALL have port clk  in  1  DDR4 UI clock; single clock domain.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port rd_issue  in  SLOTS  per-slot read command issued this cycle.
REQ-008 SHALL have port rd_data  in  DATA_WIDTH  returned read beat.
REQ-009 SHALL have port rd_data_en  in  1  rd_data valid; cannot be back-pressured.
REQ-010 SHALL have port max_pkt_len  in  16  beats per packet cap; 0 = unlimited.
REQ-011 SHALL have ports m_axis_tdata out DATA_WIDTH, m_axis_tkeep out DATA_WIDTH/8, m_axis_tlast out 1, m_axis_tvalid out 1, m_axis_tready in 1: AXIS master.
REQ-012 SHALL have port outstanding  out  CNT_WIDTH  reads issued, not yet returned.
REQ-013 SHALL have port credit_ok  out  1  scheduler may issue further reads.
REQ-014 SHALL have ports overflow out 1 and underflow out 1: sticky error flags.

Function
REQ-015 SHALL compute outstanding_next = outstanding + popcount(rd_issue) - rd_data_en, all slots and the return counted in the same cycle.
REQ-016 SHALL, when rd_data_en arrives with outstanding + popcount(rd_issue) == 0, set underflow, hold outstanding at 0, and still forward the beat with tlast=1.
REQ-017 SHALL saturate outstanding at 2^CNT_WIDTH-1 and set overflow on saturation.
REQ-018 SHALL tag a beat tlast when outstanding_next == 0 or, with max_pkt_len != 0, when its packet beat index + 1 == max_pkt_len.
REQ-019 SHALL implement packet FSM IDLE/IN_PKT: IDLE->IN_PKT on a beat without tlast; IN_PKT->IDLE on a beat with tlast; beat index cleared on tlast.
REQ-020 SHALL write each beat with its tlast into a FIFO_DEPTH FIFO; first-word latency rd_data_en -> m_axis_tvalid is 1 cycle.
REQ-021 SHALL hold m_axis_tdata/tlast stable while tvalid && !tready; pop only on tvalid && tready.
REQ-022 SHALL drive m_axis_tkeep all-ones whenever tvalid is high.
REQ-023 SHALL, on rd_data_en with FIFO full and no same-cycle pop, drop the beat, set overflow, and still update outstanding and the FSM.
REQ-024 SHALL accept a push and a pop in the same cycle when FIFO is full.
REQ-025 SHALL register credit_ok = (outstanding + fifo_count) < FIFO_DEPTH, one cycle behind its inputs.

Reset
REQ-026 SHALL, on rst (including mid-packet), flush the FIFO and clear outstanding, beat index, FSM (IDLE), overflow and underflow.
REQ-027 SHALL drive m_axis_tvalid=0, m_axis_tlast=0, outstanding=0, credit_ok=0 during reset; credit_ok=1 the first cycle after it.

Configuration
REQ-028 SHALL, with RDATA_STATS_EN defined, add outputs beat_count (32) and pkt_count (32): beats popped and tlast beats popped, wrapping, cleared by rst.
REQ-029 SHALL, without RDATA_STATS_EN, omit those ports and their logic entirely.

Structure
REQ-030 SHALL place FSM state typedef (IDLE, IN_PKT) and the default width/depth constants in shared package sddt_rdata_pkg.
REQ-031 SHALL implement buffering in sub-module rdata_sync_fifo (DATA_WIDTH+1 wide, FIFO_DEPTH deep, count output).

Verification
REQ-032 SHALL verify: rd_issue=4'b1111 one cycle, 4 beats returned, tready=1 -> 4 beats out, tlast only on 4th, outstanding 4->0.
REQ-033 SHALL verify: max_pkt_len=3, 8 reads then 8 beats -> tlast on beats 3, 6, 8.
REQ-034 SHALL verify: tready=0, 17 beats with FIFO_DEPTH=16 -> 16 stored, overflow=1, credit_ok=0.
REQ-035 SHALL verify: rd_data_en with outstanding=0 -> underflow=1, beat out with tlast=1, outstanding stays 0.
REQ-036 SHALL verify: rst asserted mid-packet with 5 beats buffered -> next cycle tvalid=0, outstanding=0, credit_ok=1 after release.
REQ-037 SHALL verify, with RDATA_STATS_EN: 2 packets of 3 beats popped -> beat_count=6, pkt_count=2.
